huff_serializer: RTL and testbench

- Parametrised successor to the fixed 9-bit Huffman serializer: converts variable-length codewords (1..MAX_LEN bits, right-aligned) into an MSB-first serial bit stream.
- Input side has a valid/ready handshake and a small codeword FIFO; output side has a valid/ready handshake, so downstream can stall.
- Sits between the Huffman code-table lookup and the output bit packer.
- Sustains 1 bit/cycle with no bubble between back-to-back codewords.

---
 rtl/huff_serializer_if.sv | 26 ++
 rtl/huff_serializer.sv | 136 +++++++++++++
 tb/tb_huff_serializer.sv | 334 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/huff_serializer_if.sv
// Codeword-in / serial-bit-out handshake bundle for huff_serializer.
// slave is the serializer's view; master is the producer/consumer view.
interface huff_serializer_if #(
  parameter int MAX_LEN = 16,
  parameter int LEN_W   = 5
);
  logic               in_valid;
  logic               in_ready;
  logic [MAX_LEN-1:0] in_code;
  logic [LEN_W-1:0]   in_len;
  logic               out_valid;
  logic               out_ready;
  logic               out_bit;
  logic               out_sop;
  logic               out_eop;

  modport slave (
    input  in_valid, in_code, in_len, out_ready,
    output in_ready, out_valid, out_bit, out_sop, out_eop
  );

  modport master (
    output in_valid, in_code, in_len, out_ready,
    input  in_ready, out_valid, out_bit, out_sop, out_eop
  );
endinterface

// File: rtl/huff_serializer.sv
// Variable-length codeword to MSB-first bit-stream serializer with input FIFO.
// Optional BIT_COUNT_EN adds a 32-bit transferred-bit counter with clear input.
module huff_serializer #(
  parameter int MAX_LEN    = 16,
  parameter int LEN_W      = 5,
  parameter int FIFO_DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               flush,
  huff_serializer_if.slave   io,
  output logic               busy,
  output logic               err
`ifdef BIT_COUNT_EN
  ,
  input  logic               bit_count_clr,
  output logic [31:0]        bit_count
`endif
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(FIFO_DEPTH);
  localparam logic [LEN_W-1:0] MAX_LEN_L = LEN_W'(MAX_LEN);
  localparam logic [LEN_W-1:0] ONE_L     = LEN_W'(1);

  logic [MAX_LEN-1:0] code_mem [FIFO_DEPTH];
  logic [LEN_W-1:0]   len_mem  [FIFO_DEPTH];

  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [MAX_LEN-1:0] sreg_q, sreg_d;
  logic [LEN_W-1:0]   rem_q, rem_d;
  logic               first_q, first_d;
  logic               err_q, err_d;

  logic               accept, len_zero, len_big, push, pop, shift, valid;
  logic [LEN_W-1:0]   wr_len, rd_len, sh_amt;

  always_comb begin
    valid    = (rem_q != '0);
    accept   = io.in_valid & io.in_ready & ~flush;
    len_zero = (io.in_len == '0);
    len_big  = (io.in_len > MAX_LEN_L);
    push     = accept & ~len_zero;
    wr_len   = len_big ? MAX_LEN_L : io.in_len;
    shift    = valid & io.out_ready;
    // A word loads into an idle shifter or straight behind the last bit leaving it.
    pop      = (count_q != '0) & ((rem_q == '0) | ((rem_q == ONE_L) & shift));
    rd_len   = len_mem[rd_ptr_q];
    sh_amt   = MAX_LEN_L - rd_len;
  end

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q + CNT_W'(push) - CNT_W'(pop);
    sreg_d   = sreg_q;
    rem_d    = rem_q;
    first_d  = first_q;
    err_d    = err_q | (accept & (len_zero | len_big));
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
      sreg_d   = code_mem[rd_ptr_q] << sh_amt;
      rem_d    = rd_len;
      first_d  = 1'b1;
    end else if (shift) begin
      sreg_d   = {sreg_q[MAX_LEN-2:0], 1'b0};
      rem_d    = rem_q - ONE_L;
      first_d  = 1'b0;
    end
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      sreg_d   = '0;
      rem_d    = '0;
      first_d  = 1'b0;
      err_d    = 1'b0;
    end
  end

  // NOTE: clocked state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      sreg_q   <= '0;
      rem_q    <= '0;
      first_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      sreg_q   <= sreg_d;
      rem_q    <= rem_d;
      first_q  <= first_d;
      err_q    <= err_d;
    end
  end

  // NOTE: FIFO storage is not reset; count_q gates every read, so stale contents are never observed.
  always_ff @(posedge clk) begin
    if (push) begin
      code_mem[wr_ptr_q] <= io.in_code;
      len_mem[wr_ptr_q]  <= wr_len;
    end
  end

  assign io.in_ready  = (count_q != FULL_CNT);
  assign io.out_valid = valid;
  assign io.out_bit   = sreg_q[MAX_LEN-1];
  assign io.out_sop   = valid & first_q;
  assign io.out_eop   = valid & (rem_q == ONE_L);
  assign busy         = (count_q != '0) | valid;
  assign err          = err_q;

`ifdef BIT_COUNT_EN
  logic [31:0] bit_count_q;

  always_ff @(posedge clk) begin
    if (rst || flush || bit_count_clr) begin
      bit_count_q <= '0;
    end else if (shift) begin
      bit_count_q <= bit_count_q + 32'd1;
    end
  end

  assign bit_count = bit_count_q;
`endif

endmodule

// File: tb/tb_huff_serializer.sv
// Scoreboard bench for huff_serializer: accepted codewords expand into expected
// bit beats in a queue; a negedge monitor pops and compares every transferred bit.
`timescale 1ns/1ps
module tb_huff_serializer;
  localparam int MAX_LEN    = 16;
  localparam int LEN_W      = 5;
  localparam int FIFO_DEPTH = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic flush = 1'b0;
  logic busy, err;
`ifdef BIT_COUNT_EN
  logic        bit_count_clr = 1'b0;
  logic [31:0] bit_count;
`endif

  huff_serializer_if #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W)) bus ();

  huff_serializer #(
    .MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .FIFO_DEPTH(FIFO_DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .flush(flush),
    .io(bus),
    .busy(busy),
    .err(err)
`ifdef BIT_COUNT_EN
    ,
    .bit_count_clr(bit_count_clr),
    .bit_count(bit_count)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic b;
    logic sop;
    logic eop;
  } beat_t;

  beat_t exp_q[$];
  int    n_checks = 0;
  int    n_fail = 0;
  int    beats_seen = 0;
  bit    model_err = 1'b0;
  bit    prev_stall = 1'b0;
  beat_t prev_beat, mon_cur, mon_exp;
  bit    rand_done;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: a word of length L is bits L-1 down to 0 of the code, first bit flagged sop, last eop.
  task automatic model_push(input logic [MAX_LEN-1:0] code, input int len);
    int l;
    beat_t bt;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    for (int i = l - 1; i >= 0; i--) begin
      bt.b   = code[i];
      bt.sop = (i == l - 1);
      bt.eop = (i == 0);
      exp_q.push_back(bt);
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      model_err  = 1'b0;
      prev_stall = 1'b0;
    end else begin
      mon_cur = {bus.out_bit, bus.out_sop, bus.out_eop};
      check("err", err, model_err);
      check("busy", busy, exp_q.size() != 0);
      if (prev_stall) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_beat", mon_cur, prev_beat);
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_beat", bus.out_valid, 0);
        end else begin
          mon_exp = exp_q.pop_front();
          check("beat", mon_cur, mon_exp);
          beats_seen++;
        end
      end
      prev_stall = bus.out_valid && !bus.out_ready && !flush;
      prev_beat  = mon_cur;
      if (flush) begin
        exp_q.delete();
        model_err = 1'b0;
      end else if (bus.in_valid && bus.in_ready) begin
        if (bus.in_len == 0 || int'(bus.in_len) > MAX_LEN) model_err = 1'b1;
        model_push(bus.in_code, int'(bus.in_len));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [MAX_LEN-1:0] code, input logic [LEN_W-1:0] len);
    int waited;
    waited = 0;
    bus.in_valid = 1'b1;
    bus.in_code  = code;
    bus.in_len   = len;
    while (!bus.in_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (waited >= 200) check("send_timeout", bus.in_ready, 1);
    tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 2000);
    if (busy) check("idle_timeout", busy, 0);
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int b0, exp_bits;
    logic [LEN_W-1:0] lenr;
    int r;

    bus.in_valid  = 1'b0;
    bus.in_code   = '0;
    bus.in_len    = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_in_ready", bus.in_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_err", err, 0);
    check("rst_out_bit", bus.out_bit, 0);
    check("rst_sop_eop", {bus.out_sop, bus.out_eop}, 0);
    tick();

    // Single 9-bit word, latency of two edges
    bus.out_ready = 1'b1;
    b0 = beats_seen;
    send(16'h0165, 5'd9);
    @(negedge clk);
    check("lat_early_valid", bus.out_valid, 0);
    @(negedge clk);
    check("lat_valid", bus.out_valid, 1);
    check("lat_sop", bus.out_sop, 1);
    wait_idle();
    check("t1_beats", beats_seen - b0, 9);

    // Back-to-back words leave no bubble
    bus.out_ready = 1'b0;
    b0 = beats_seen;
    send(16'b10, 5'd2);
    send(16'b1, 5'd1);
    send(16'b011, 5'd3);
    tick();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("b2b_valid", bus.out_valid, 1);
    end
    @(negedge clk);
    check("b2b_end_valid", bus.out_valid, 0);
    tick();
    check("b2b_beats", beats_seen - b0, 6);

    // Back-pressure: shifter plus FIFO_DEPTH words, then in_ready drops
    bus.out_ready = 1'b0;
    b0 = beats_seen;
    exp_bits = 0;
    for (int i = 0; i < FIFO_DEPTH + 1; i++) begin
      lenr = LEN_W'($urandom_range(2, MAX_LEN));
      exp_bits += int'(lenr);
      check("fill_in_ready", bus.in_ready, 1);
      send(MAX_LEN'($urandom()), lenr);
    end
    bus.in_valid = 1'b1;
    bus.in_code  = 16'hFFFF;
    bus.in_len   = 5'd4;
    repeat (4) begin
      @(negedge clk);
      check("full_in_ready", bus.in_ready, 0);
      check("full_out_valid", bus.out_valid, 1);
    end
    tick();
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    wait_idle();
    check("full_beats", beats_seen - b0, exp_bits);

    // Length errors: zero dropped, oversize clamped; err sticky until flush
    b0 = beats_seen;
    send(16'h1234, 5'd0);
    @(negedge clk);
    check("len0_err", err, 1);
    check("len0_busy", busy, 0);
    check("len0_valid", bus.out_valid, 0);
    tick();
    send(16'hA5C3, 5'd20);
    wait_idle();
    check("len20_beats", beats_seen - b0, 16);
    check("len20_err_sticky", err, 1);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    @(negedge clk);
    check("flush_err", err, 0);
    tick();

    // Flush mid-word with words queued; a beat offered during flush is discarded
    bus.out_ready = 1'b0;
    send(16'h00B4, 5'd8);
    send(16'h0015, 5'd5);
    send(16'h002A, 5'd6);
    tick();
    bus.out_ready = 1'b1;
    repeat (3) tick();
    flush        = 1'b1;
    bus.in_valid = 1'b1;
    bus.in_code  = 16'h000F;
    bus.in_len   = 5'd4;
    tick();
    flush        = 1'b0;
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("flush_valid", bus.out_valid, 0);
    check("flush_busy", busy, 0);
    check("flush_in_ready", bus.in_ready, 1);
    repeat (10) @(negedge clk);
    check("flush_quiet", busy, 0);
    tick();

`ifdef BIT_COUNT_EN
    check("cnt_after_flush", bit_count, 0);
    send(MAX_LEN'($urandom()), 5'd5);
    send(MAX_LEN'($urandom()), 5'd7);
    send(MAX_LEN'($urandom()), 5'd16);
    wait_idle();
    check("cnt_28", bit_count, 28);
    bit_count_clr = 1'b1;
    tick();
    bit_count_clr = 1'b0;
    @(negedge clk);
    check("cnt_clr", bit_count, 0);
    tick();
    bus.out_ready = 1'b0;
    send(16'h0009, 5'd4);
    tick();
    bus.out_ready = 1'b1;
    bit_count_clr = 1'b1;
    tick();
    bit_count_clr = 1'b0;
    bus.out_ready = 1'b0;
    @(negedge clk);
    check("cnt_clr_wins", bit_count, 0);
    tick();
    bus.out_ready = 1'b1;
    wait_idle();
    check("cnt_after_clr", bit_count, 3);
`endif

    // Reset mid-codeword discards the rest of the word
    bus.out_ready = 1'b1;
    send(16'hFFFF, 5'd16);
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    @(negedge clk);
    check("rstmid_valid", bus.out_valid, 0);
    check("rstmid_busy", busy, 0);
    check("rstmid_in_ready", bus.in_ready, 1);
    repeat (10) @(negedge clk);
    tick();

    // Randomized traffic with random back-pressure
    rand_done = 1'b0;
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          repeat ($urandom_range(0, 2)) tick();
          r = $urandom_range(0, 19);
          if (r == 0) lenr = '0;
          else if (r >= 17) lenr = LEN_W'($urandom_range(MAX_LEN + 1, 31));
          else lenr = LEN_W'(r);
          send(MAX_LEN'($urandom()), lenr);
        end
        rand_done = 1'b1;
      end
      begin
        while (!rand_done) begin
          tick();
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_idle();
    check("final_queue_empty", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
